instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Program loader for the non-pipelined MIPS core, and the write side of the instruction memory that the fetch path reads through `pc`. It receives a byte stream over a valid/ready handshake and packs it into big-endian 32-bit MIPS instruction words. It writes each word to consecutive word addresses starting at 0. While loading, it holds the processor stalled through `cpu_hold`.

## Interface
- `ADDR_WIDTH`, 16: width of `wr_addr`; matches the instruction-memory `pc` width.
- `DEPTH`, 256: number of 32-bit words in the instruction memory.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a load; sampled only in IDLE.
- `word_count`  in  9: number of words to load; latched on an accepted `start`; legal range 1..DEPTH.
- `byte_in`  in  8: incoming program byte.
- `byte_valid`  in  1: `byte_in` is valid this cycle.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `wr_en`  out  1: instruction-memory write strobe, one cycle per word.
- `wr_addr`  out  ADDR_WIDTH: word index; the same index space as `pc`.
- `wr_data`  out  32: assembled instruction word.
- `busy`  out  1: a load is in progress.
- `cpu_hold`  out  1: processor must not fetch while this is high.
- `done`  out  1: one-cycle pulse after the last word is written.
- `error`  out  1: one-cycle pulse when `start` carries an illegal `word_count`.

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Word index, byte counter and assembly register are 0.
- Every output comes from a register. None is combinational from an input.
- IDLE:
  - `byte_ready`=0, `busy`=0, `cpu_hold`=0.
  - On `start`=1 with 1 ≤ `word_count` ≤ DEPTH: latch the count, clear the word index and byte counter, then go to RECV with `busy`=`cpu_hold`=1.
  - On `start`=1 with `word_count`=0 or `word_count`>DEPTH: pulse `error` for one cycle and stay in IDLE.
- RECV:
  - `byte_ready`=1.
  - A byte is accepted on any cycle with `byte_valid`&&`byte_ready`. The assembly register shifts: asm <= {asm[23:0], byte_in}. The byte counter increments.
  - Byte order is big-endian: the first byte lands in bits 31:24.
  - `byte_valid`=0 cycles are stalls. No state changes.
  - The 4th accepted byte moves the FSM to WRITE, and `byte_ready` deasserts in that same transition.
- WRITE (exactly one cycle):
  - `wr_en`=1, `wr_addr`=word index (zero-extended), `wr_data`=assembled word.
  - If word index = count−1, go to DONE.
  - Otherwise increment the word index, clear the byte counter and return to RECV.
- DONE (one cycle):
  - `done`=1.
  - Next cycle: IDLE, with `busy`=`cpu_hold`=0.
- `start` outside IDLE is ignored. It does not restart the load or change the count.
- `byte_valid` while `byte_ready`=0 is ignored. The byte is neither consumed nor buffered.
- Reset mid-load:
  - Return to IDLE immediately and drop `cpu_hold`.
  - Words already written remain in memory. The partial word is discarded.
- `wr_addr` never exceeds DEPTH−1.

## Timing
- Start is accepted on edge 0. RECV (`byte_ready`=1) is visible after edge 0.
- With continuous `byte_valid`:
  - 4 bytes are accepted on edges 1–4.
  - `wr_en` is high for the cycle after edge 4.
  - The next word's RECV begins after edge 5.
  - This gives 5 cycles per word.
- K words with no stalls:
  - `done` is visible after edge 5K+1.
  - `busy` and `cpu_hold` fall after edge 5K+2.
- Each stall cycle delays all later events by one cycle.
- `error` is visible for exactly the one cycle after the edge that sampled the illegal `start`.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle → all outputs read 0 immediately. After release, `byte_ready`=0 until `start`.
- Single word:
  - Stimulus: `word_count`=1, bytes 8C,01,00,04 back-to-back.
  - Required: one `wr_en` pulse with `wr_addr`=0 and `wr_data`=0x8C010004; `done` one cycle later; `cpu_hold` low after that.
- Three words with stalls:
  - Stimulus: `word_count`=3, `byte_valid` toggling 1/0, bytes 00..0B.
  - Required: writes 0x00010203@0, 0x04050607@1, 0x08090A0B@2; exactly 3 `wr_en` pulses; `byte_valid` during WRITE is not consumed.
- Illegal count:
  - Stimulus: `start` with `word_count`=0, then with 257.
  - Required: one `error` pulse each time; `busy` stays 0; no `wr_en`.
- Start while busy and reset mid-load:
  - Stimulus: `start` with `word_count`=5 at word 1 → count unchanged, still 5 words.
  - Stimulus: `rst` after 2 bytes of word 3 → no write to address 3; IDLE; `cpu_hold`=0.
- Full depth:
  - Stimulus: `word_count`=256, incrementing pattern.
  - Required: last write at `wr_addr`=255; `done` exactly 1281 cycles after start acceptance with no stalls.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// Loader-side bus: byte-stream handshake from the program source plus the
// instruction-memory write port and CPU status lines.
interface instr_mem_loader_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic [8:0]            word_count;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  busy;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, error
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, error
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit instruction words
// and writes them to word addresses 0..count-1 while holding the CPU.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_loader_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  state_t           state_r;
  logic [8:0]       count_r;
  logic [IDX_W-1:0] word_idx_r;
  logic [1:0]       byte_cnt_r;
  logic [31:0]      asm_r;
  logic             byte_ready_r;
  logic             wr_en_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;

  logic             start_legal_s;
  logic             last_word_s;

  // Count legality and last-word detection
  always_comb begin
    start_legal_s = (bus.word_count != 9'd0) && (bus.word_count <= 9'(DEPTH));
    last_word_s   = (9'(word_idx_r) == (count_r - 9'd1));
  end

  // Load sequencer with registered handshake, write and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      count_r      <= 9'd0;
      word_idx_r   <= '0;
      byte_cnt_r   <= 2'd0;
      asm_r        <= 32'd0;
      byte_ready_r <= 1'b0;
      wr_en_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          byte_ready_r <= 1'b0;
          wr_en_r      <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          error_r      <= 1'b0;
          if (bus.start) begin
            if (start_legal_s) begin
              count_r      <= bus.word_count;
              word_idx_r   <= '0;
              byte_cnt_r   <= 2'd0;
              busy_r       <= 1'b1;
              byte_ready_r <= 1'b1;
              state_r      <= S_RECV;
            end else begin
              error_r <= 1'b1;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RECV: begin
          if (bus.byte_valid && byte_ready_r) begin
            asm_r      <= {asm_r[23:0], bus.byte_in};
            byte_cnt_r <= byte_cnt_r + 2'd1;
            // The fourth byte completes the word; ready drops on the same edge
            if (byte_cnt_r == 2'd3) begin
              byte_ready_r <= 1'b0;
              wr_en_r      <= 1'b1;
              state_r      <= S_WRITE;
            end else begin
              state_r <= S_RECV;
            end
          end else begin
            state_r <= S_RECV;
          end
        end
        S_WRITE: begin
          wr_en_r <= 1'b0;
          if (last_word_s) begin
            state_r <= S_DONE;
          end else begin
            word_idx_r   <= word_idx_r + IDX_W'(1'b1);
            byte_cnt_r   <= 2'd0;
            byte_ready_r <= 1'b1;
            state_r      <= S_RECV;
          end
        end
        S_DONE: begin
          done_r  <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          byte_ready_r <= 1'b0;
          wr_en_r      <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          error_r      <= 1'b0;
          state_r      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_r;
  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = ADDR_WIDTH'(word_idx_r);
  assign bus.wr_data    = asm_r;
  assign bus.busy       = busy_r;
  assign bus.cpu_hold   = busy_r;
  assign bus.done       = done_r;
  assign bus.error      = error_r;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized and directed bench for instr_mem_loader, checked every cycle
// against an event-timeline model of the load protocol.
module tb_instr_mem_loader;
  localparam int MAXC = 1400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.ADDR_WIDTH(16)) bus ();
  instr_mem_loader #(.ADDR_WIDTH(16), .DEPTH(256)) dut (.clk(clk), .rst(rst), .bus(bus));

  bit          st [MAXC];
  logic [8:0]  wc [MAXC];
  bit          bv [MAXC];
  logic [7:0]  bi [MAXC];
  bit          e_rdy [MAXC];
  bit          e_wr [MAXC];
  bit          e_busy [MAXC];
  bit          e_done [MAXC];
  bit          e_err [MAXC];
  logic [15:0] e_addr [MAXC];
  logic [31:0] e_data [MAXC];
  logic [7:0]  prog [1200];
  logic [31:0] mdl_wq [$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_stim(input int n);
    for (int i = 0; i < n; i++) begin
      st[i] = 1'b0;
      wc[i] = 9'd0;
      bv[i] = 1'b0;
    end
  endtask

  // Timeline model: walks the stimulus word by word and marks, for every edge,
  // what each output must show after that edge.
  task automatic plan(input int n);
    int c, e, r, ptr, k, nb, endb;
    bit stop;
    logic [31:0] word_v;
    mdl_wq.delete();
    for (int i = 0; i < n; i++) begin
      e_rdy[i] = 1'b0; e_wr[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0;
      e_addr[i] = 16'd0; e_data[i] = 32'd0;
      bi[i] = 8'($urandom);
    end
    ptr = 0;
    c = 0;
    while (c < n) begin
      if (st[c] && wc[c] >= 9'd1 && wc[c] <= 9'd256) begin
        k = int'(wc[c]);
        r = c;
        e = c;
        stop = 1'b0;
        for (int w = 0; w < k; w++) begin
          nb = 0;
          e = r;
          word_v = 32'd0;
          while (nb < 4) begin
            e++;
            if (e >= n) begin
              stop = 1'b1;
              break;
            end
            bi[e] = prog[ptr];
            if (bv[e]) begin
              word_v = (word_v << 8) | 32'(prog[ptr]);
              ptr++;
              nb++;
            end
          end
          for (int t = r; t < e && t < n; t++) e_rdy[t] = 1'b1;
          if (stop) break;
          e_wr[e] = 1'b1;
          e_addr[e] = 16'(w);
          e_data[e] = word_v;
          mdl_wq.push_back(word_v);
          r = e + 1;
        end
        endb = stop ? n - 1 : e + 2;
        if (endb > n - 1) endb = n - 1;
        for (int t = c; t <= endb; t++) e_busy[t] = 1'b1;
        if (!stop && e + 2 < n) e_done[e + 2] = 1'b1;
        c = stop ? n : e + 3;
      end else begin
        if (st[c]) e_err[c] = 1'b1;
        c++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.start = st[c];
      bus.word_count = wc[c];
      bus.byte_valid = bv[c];
      bus.byte_in = bi[c];
      cyc = c;
      chk_en = 1'b1;
    end
    @(negedge clk);
    chk_en = 1'b0;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.word_count = 9'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " byte_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, " wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({tag, " wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, " wr_data"}, bus.wr_data, 32'd0);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " cpu_hold"}, 32'(bus.cpu_hold), 32'd0);
    chk({tag, " done"}, 32'(bus.done), 32'd0);
    chk({tag, " error"}, 32'(bus.error), 32'd0);
  endtask

  // Per-cycle comparison of every output against the model
  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      chk($sformatf("byte_ready@%0d", cyc), 32'(bus.byte_ready), 32'(e_rdy[cyc]));
      chk($sformatf("wr_en@%0d", cyc), 32'(bus.wr_en), 32'(e_wr[cyc]));
      chk($sformatf("busy@%0d", cyc), 32'(bus.busy), 32'(e_busy[cyc]));
      chk($sformatf("cpu_hold@%0d", cyc), 32'(bus.cpu_hold), 32'(e_busy[cyc]));
      chk($sformatf("done@%0d", cyc), 32'(bus.done), 32'(e_done[cyc]));
      chk($sformatf("error@%0d", cyc), 32'(bus.error), 32'(e_err[cyc]));
      if (e_wr[cyc]) begin
        chk($sformatf("wr_addr@%0d", cyc), 32'(bus.wr_addr), 32'(e_addr[cyc]));
        chk($sformatf("wr_data@%0d", cyc), bus.wr_data, e_data[cyc]);
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.word_count = 9'd0;
    bus.byte_in = 8'd0;
    bus.byte_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: ready stays low without start
    clear_stim(6);
    plan(6);
    run(6);

    // Single word 8C 01 00 04
    clear_stim(12);
    prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h04;
    st[1] = 1'b1; wc[1] = 9'd1;
    for (int i = 0; i < 12; i++) bv[i] = 1'b1;
    plan(12);
    chk("model single wr_en", 32'(e_wr[5]), 32'd1);
    chk("model single data", e_data[5], 32'h8C010004);
    chk("model single done", 32'(e_done[7]), 32'd1);
    chk("model single busy off", 32'(e_busy[8]), 32'd0);
    run(12);

    // Three words, valid toggling, bytes 00..0B
    clear_stim(40);
    for (int i = 0; i < 12; i++) prog[i] = 8'(i);
    st[1] = 1'b1; wc[1] = 9'd3;
    for (int i = 2; i < 40; i++) bv[i] = (i % 2 == 0);
    plan(40);
    chk("model 3w count", 32'(mdl_wq.size()), 32'd3);
    chk("model 3w word0", mdl_wq[0], 32'h00010203);
    chk("model 3w word1", mdl_wq[1], 32'h04050607);
    chk("model 3w word2", mdl_wq[2], 32'h08090A0B);
    run(40);

    // Illegal counts 0 and 257
    clear_stim(10);
    st[1] = 1'b1; wc[1] = 9'd0;
    st[4] = 1'b1; wc[4] = 9'd257;
    plan(10);
    chk("model err0", 32'(e_err[1]), 32'd1);
    chk("model err257", 32'(e_err[4]), 32'd1);
    run(10);

    // Start while busy, then reset after two bytes of word 3
    clear_stim(19);
    for (int i = 0; i < 40; i++) prog[i] = 8'($urandom);
    st[1] = 1'b1; wc[1] = 9'd5;
    st[8] = 1'b1; wc[8] = 9'd2;
    for (int i = 0; i < 19; i++) bv[i] = 1'b1;
    plan(19);
    chk("model midload writes", 32'(mdl_wq.size()), 32'd3);
    run(19);
    #2 rst = 1'b1;
    #1 chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_stim(6);
    plan(6);
    run(6);

    // Randomized loads with stalls, illegal starts and garbage during WRITE
    for (int s = 0; s < 6; s++) begin
      clear_stim(300);
      for (int i = 0; i < 1200; i++) prog[i] = 8'($urandom);
      for (int c = 1; c < 40; c++) begin
        if ($urandom_range(0, 9) == 0) begin
          st[c] = 1'b1;
          case ($urandom_range(0, 11))
            9: wc[c] = 9'd257;
            10: wc[c] = 9'd400;
            11: wc[c] = 9'd511;
            default: wc[c] = 9'($urandom_range(0, 8));
          endcase
        end
      end
      for (int c = 0; c < 300; c++) bv[c] = ($urandom_range(0, 3) != 0);
      plan(300);
      run(300);
    end

    // Full depth, incrementing pattern, no stalls
    clear_stim(1290);
    for (int i = 0; i < 1024; i++) prog[i] = 8'(i);
    st[1] = 1'b1; wc[1] = 9'd256;
    for (int i = 0; i < 1290; i++) bv[i] = 1'b1;
    plan(1290);
    chk("model full last wr", 32'(e_wr[1280]), 32'd1);
    chk("model full last addr", 32'(e_addr[1280]), 32'd255);
    chk("model full done", 32'(e_done[1282]), 32'd1);
    chk("model full words", 32'(mdl_wq.size()), 32'd256);
    run(1290);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
